// File: rtl/params_pkg.sv
// Shared types and sizing for the TLB controller and its entry CAM.
package params_pkg;

  localparam int VADDR_WIDTH       = 32;
  localparam int PADDR_WIDTH       = 20;
  localparam int DATA_WIDTH        = 32;
  localparam int PAGE_OFFSET_WIDTH = 12;
  localparam int VPN_WIDTH         = VADDR_WIDTH - PAGE_OFFSET_WIDTH;
  localparam int PPN_WIDTH         = PADDR_WIDTH - PAGE_OFFSET_WIDTH;
  localparam int TLB_ENTRIES       = 4;

  typedef logic [VADDR_WIDTH-1:0] vaddr_t;
  typedef logic [PADDR_WIDTH-1:0] paddr_t;
  typedef logic [DATA_WIDTH-1:0]  data_t;

  typedef struct packed {
    logic                 valid;
    logic [VPN_WIDTH-1:0] vpn;
    logic [PPN_WIDTH-1:0] ppn;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WALK,
    RESP
  } tlb_state_e;

  function automatic logic [VPN_WIDTH-1:0] vpn_of(input vaddr_t va);
    return va[VADDR_WIDTH-1:PAGE_OFFSET_WIDTH];
  endfunction

endpackage

// File: rtl/tlb_cam.sv
// Fully-associative translation entry array: parallel VPN compare, victim choice and fill.
module tlb_cam
  import params_pkg::*;
#(
  parameter int NUM_ENTRIES = TLB_ENTRIES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [VPN_WIDTH-1:0] lookup_vpn,
  output logic                 hit,
  output logic [PPN_WIDTH-1:0] hit_ppn,
  input  logic                 fill,
  input  logic [VPN_WIDTH-1:0] fill_vpn,
  input  logic [PPN_WIDTH-1:0] fill_ppn
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  tlb_entry_t       entries_q [NUM_ENTRIES];
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] victim;
  logic             victim_is_ptr;

  // Entries never hold duplicate VPNs, so OR-ing the matching PPNs is safe.
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (entries_q[i].valid && (entries_q[i].vpn == lookup_vpn)) begin
        hit     = 1'b1;
        hit_ppn = hit_ppn | entries_q[i].ppn;
      end
    end
  end

  always_comb begin
    victim        = rr_ptr_q;
    victim_is_ptr = 1'b1;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) begin
        victim        = IDX_W'(i);
        victim_is_ptr = 1'b0;
      end
    end
  end

  // Flush has priority over a coincident fill; the pointer only moves when it chose the victim.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
      rr_ptr_q <= '0;
    end else if (fill) begin
      entries_q[victim] <= '{valid: 1'b1, vpn: fill_vpn, ppn: fill_ppn};
      if (victim_is_ptr) begin
        rr_ptr_q <= (rr_ptr_q == IDX_W'(NUM_ENTRIES - 1)) ? '0 : rr_ptr_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/tlb_ctrl.sv
// TLB controller: single outstanding request, CAM lookup, page-table walk on miss, one-cycle response.
module tlb_ctrl
  import params_pkg::*;
#(
  parameter int NUM_ENTRIES = TLB_ENTRIES,
  parameter int PADDR_WIDTH = params_pkg::PADDR_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  vaddr_t                 req_vaddr_i,
  input  data_t                  satp_data_i,
  input  logic                   flush_i,
  output logic                   resp_valid_o,
  output logic [PADDR_WIDTH-1:0] resp_paddr_o,
  output logic                   resp_error_o,
  output logic                   ptw_req_o,
  output vaddr_t                 ptw_vaddr_o,
  output data_t                  ptw_satp_o,
  input  logic                   ptw_valid_i,
  input  logic                   ptw_error_i,
  input  logic [PADDR_WIDTH-1:0] ptw_paddr_i
);

  tlb_state_e             state_q, state_d;
  vaddr_t                 vaddr_q, vaddr_d;
  logic [PADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                   error_q, error_d;
  logic                   accept;
  logic                   fill;
  logic                   cam_hit;
  logic [PPN_WIDTH-1:0]   cam_hit_ppn;
  logic [PPN_WIDTH-1:0]   walk_ppn;
  logic                   ptw_offset_unused;

  // The walker returns a page-aligned address; its offset bits carry no information.
  assign ptw_offset_unused = ^ptw_paddr_i[PAGE_OFFSET_WIDTH-1:0];
  assign walk_ppn          = PPN_WIDTH'(ptw_paddr_i[PADDR_WIDTH-1:PAGE_OFFSET_WIDTH]);
  assign ptw_satp_o        = satp_data_i;

  tlb_cam #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_cam (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush_i),
    .lookup_vpn(vpn_of(vaddr_q)),
    .hit       (cam_hit),
    .hit_ppn   (cam_hit_ppn),
    .fill      (fill),
    .fill_vpn  (vpn_of(vaddr_q)),
    .fill_ppn  (walk_ppn)
  );

  always_comb begin
    state_d      = state_q;
    vaddr_d      = vaddr_q;
    paddr_d      = paddr_q;
    error_d      = error_q;
    accept       = 1'b0;
    fill         = 1'b0;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_paddr_o = '0;
    resp_error_o = 1'b0;
    ptw_req_o    = 1'b0;
    ptw_vaddr_o  = '0;

    case (state_q)
      IDLE: begin
        req_ready_o = !flush_i && !rst_i;
        accept      = req_valid_i && req_ready_o;
        if (accept) begin
          vaddr_d = req_vaddr_i;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (cam_hit) begin
          paddr_d = PADDR_WIDTH'({cam_hit_ppn, vaddr_q[PAGE_OFFSET_WIDTH-1:0]});
          error_d = 1'b0;
          state_d = RESP;
        end else begin
          state_d = WALK;
        end
      end
      WALK: begin
        ptw_req_o   = 1'b1;
        ptw_vaddr_o = {vpn_of(vaddr_q), {PAGE_OFFSET_WIDTH{1'b0}}};
        // A fault outranks a simultaneous success and must not populate the array.
        if (ptw_error_i) begin
          paddr_d = '0;
          error_d = 1'b1;
          state_d = RESP;
        end else if (ptw_valid_i) begin
          paddr_d = PADDR_WIDTH'({walk_ppn, vaddr_q[PAGE_OFFSET_WIDTH-1:0]});
          error_d = 1'b0;
          fill    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        resp_paddr_o = paddr_q;
        resp_error_o = error_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rst_i) begin
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      resp_paddr_o = '0;
      resp_error_o = 1'b0;
      ptw_req_o    = 1'b0;
      ptw_vaddr_o  = '0;
      fill         = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      vaddr_q <= '0;
      paddr_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      paddr_q <= paddr_d;
      error_q <= error_d;
    end
  end

endmodule
